// File: rtl/lbist_ctrl.sv
//------------------------------------------------------------------------------
// Module      : lbist_ctrl
// Description : Logic BIST controller. Seeds an external LFSR, sequences a
//               counted run of test patterns, compacts the circuit-under-test
//               responses into a signature and compares it against a golden
//               value. Optional macro LBIST_CTRL_MISR_EN selects a polynomial
//               MISR compactor; when undefined, a plain XOR accumulator is used.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module lbist_ctrl #(
  parameter int                N         = 16,
  parameter int                CNT_W     = 16,
  parameter int                RESP_W    = 17,
  parameter logic [RESP_W-1:0] MISR_POLY = 17'h1002D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [N:0]        seed,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [RESP_W-1:0] golden,
  input  logic [RESP_W-1:0] cut_resp,
  output logic              lfsr_rst,
  output logic [N:0]        lfsr_seed,
  output logic              test_mode,
  output logic              pat_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] signature,
  output logic [CNT_W-1:0]  pat_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEED    = 3'd1,
    S_RUN     = 3'd2,
    S_FLUSH   = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   num_lat;
  logic [RESP_W-1:0]  golden_lat;
  logic [RESP_W-1:0]  sig_nxt;
  logic [CNT_W-1:0]   last_idx;
  logic               accept;
  logic               capture;
  logic               abort_hit;

  // Index of the final pattern; only consulted in RUN where num_lat is nonzero.
  assign last_idx = num_lat - CNT_W'(1);

  // Signature update applied on each response capture.
`ifdef LBIST_CTRL_MISR_EN
  assign sig_nxt = ({signature[RESP_W-2:0], 1'b0}
                    ^ (signature[RESP_W-1] ? MISR_POLY : {RESP_W{1'b0}}))
                   ^ cut_resp;
`else
  logic unused_poly;
  assign unused_poly = ^MISR_POLY;
  assign sig_nxt     = signature ^ cut_resp;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt = state;
    lfsr_rst  = 1'b0;
    test_mode = 1'b0;
    pat_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    abort_hit = 1'b0;
    case (state)
      S_IDLE: begin
        lfsr_rst = 1'b1;
        busy     = 1'b0;
        // Abort has priority over a simultaneous start.
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = S_SEED;
        end
      end
      S_SEED: begin
        lfsr_rst = 1'b1;
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = S_DONE;
        end else if (num_lat != '0) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_COMPARE;
        end
      end
      S_RUN: begin
        test_mode = 1'b1;
        pat_valid = 1'b1;
        // The first RUN cycle has no response yet; every later one does.
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = S_DONE;
        end else begin
          capture = (pat_count != '0);
          if (pat_count == last_idx) begin
            state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        test_mode = 1'b1;
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = S_DONE;
        end else begin
          capture   = 1'b1;
          state_nxt = S_COMPARE;
        end
      end
      S_COMPARE: begin
        abort_hit = abort;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Run configuration, pattern counter, signature and verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_seed  <= '0;
      num_lat    <= '0;
      golden_lat <= '0;
      signature  <= '0;
      pass       <= 1'b0;
      pat_count  <= '0;
    end else begin
      if (accept) begin
        lfsr_seed  <= seed;
        num_lat    <= num_patterns;
        golden_lat <= golden;
        signature  <= '0;
        pass       <= 1'b0;
        pat_count  <= '0;
      end else begin
        // Counter advances on every RUN cycle, including one cut short by abort.
        if (state == S_RUN) begin
          pat_count <= pat_count + CNT_W'(1);
        end
        if (capture) begin
          signature <= sig_nxt;
        end
        if (abort_hit) begin
          pass <= 1'b0;
        end else if (state == S_COMPARE) begin
          pass <= (signature == golden_lat);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lbist_ctrl.sv
`timescale 1ns/1ps
`default_nettype none

module tb_lbist_ctrl;

  localparam int N      = 16;
  localparam int CNT_W  = 16;
  localparam int RESP_W = 17;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [N:0]        seed = '0;
  logic [CNT_W-1:0]  num_patterns = '0;
  logic [RESP_W-1:0] golden = '0;
  logic [RESP_W-1:0] cut_resp = '0;
  logic              lfsr_rst;
  logic [N:0]        lfsr_seed;
  logic              test_mode;
  logic              pat_valid;
  logic              busy;
  logic              done;
  logic              pass;
  logic [RESP_W-1:0] signature;
  logic [CNT_W-1:0]  pat_count;

  typedef struct packed {
    logic [RESP_W-1:0] sig;
    logic              pass;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t              exp_q[$];
  logic [RESP_W-1:0] resp[$];
  int                errors = 0;
  int                checks = 0;

  lbist_ctrl #(
    .N(N), .CNT_W(CNT_W), .RESP_W(RESP_W), .MISR_POLY(17'h1002D)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed),
    .num_patterns(num_patterns), .golden(golden), .cut_resp(cut_resp),
    .lfsr_rst(lfsr_rst), .lfsr_seed(lfsr_seed), .test_mode(test_mode),
    .pat_valid(pat_valid), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pat_count(pat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference compaction of the first k responses in resp[].
  function automatic logic [RESP_W-1:0] calc_sig(input int k);
    logic [RESP_W-1:0] s;
    s = '0;
    for (int i = 0; i < k; i++) begin
`ifdef LBIST_CTRL_MISR_EN
      s = ({s[RESP_W-2:0], 1'b0} ^ (s[RESP_W-1] ? 17'h1002D : 17'h0)) ^ resp[i];
`else
      s = s ^ resp[i];
`endif
    end
    return s;
  endfunction

  // Scoreboard: every done pulse retires one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_signature", 64'(signature), 64'(e.sig));
        check("sb_pass", 64'(pass), 64'(e.pass));
        check("sb_pat_count", 64'(pat_count), 64'(e.cnt));
      end
    end
  end

  // One test run: n patterns, golden g, abort during cycle a (0 = none).
  // Cycle 1 follows the start edge (SEED), RUN is 2..n+1, captures 3..n+2.
  task automatic do_run(input logic [RESP_W-1:0] s, input int n,
                        input logic [RESP_W-1:0] g, input int a);
    exp_t              e;
    int                last_cap;
    int                d;
    int                c;
    bit                seen;
    logic [RESP_W-1:0] sig;
    last_cap = n + 2;
    if (a > 0 && a - 1 < last_cap) last_cap = a - 1;
    sig = calc_sig((last_cap > 2) ? last_cap - 2 : 0);
    e.sig  = sig;
    e.pass = (a > 0) ? 1'b0 : (sig == g);
    if (a == 0)          e.cnt = CNT_W'(n);
    else if (a <= 1)     e.cnt = '0;
    else if (a - 1 < n)  e.cnt = CNT_W'(a - 1);
    else                 e.cnt = CNT_W'(n);
    d = (a > 0) ? a + 1 : ((n > 0) ? n + 4 : 3);
    exp_q.push_back(e);

    @(negedge clk);
    start = 1'b1; seed = s; num_patterns = CNT_W'(n); golden = g;
    @(negedge clk);
    start = 1'b0;
    seed = RESP_W'($urandom); num_patterns = CNT_W'($urandom); golden = RESP_W'($urandom);
    c = 1;
    seen = 0;
    while (!seen && c <= d + 3) begin
      cut_resp = (c >= 3 && c <= n + 2) ? resp[c-3] : RESP_W'($urandom);
      abort    = (c == a);
      start    = (c == 2);
      if (c == 1) check("lfsr_seed", 64'(lfsr_seed), 64'(s));
      if (c < d) begin
        check("pat_valid", 64'(pat_valid), 64'(c >= 2 && c <= n + 1));
        check("test_mode", 64'(test_mode), 64'(n > 0 && c >= 2 && c <= n + 2));
        check("lfsr_rst", 64'(lfsr_rst), 64'(c == 1));
        check("busy", 64'(busy), 64'd1);
      end
      check("done", 64'(done), 64'(c == d));
      if (done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_lfsr_rst", 64'(lfsr_rst), 64'd1);
    check("hold_signature", 64'(signature), 64'(e.sig));
    check("hold_pass", 64'(pass), 64'(e.pass));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lfsr_rst"}, 64'(lfsr_rst), 64'd1);
    check({tag, "_lfsr_seed"}, 64'(lfsr_seed), 64'd0);
    check({tag, "_test_mode"}, 64'(test_mode), 64'd0);
    check({tag, "_pat_valid"}, 64'(pat_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_signature"}, 64'(signature), 64'd0);
    check({tag, "_pat_count"}, 64'(pat_count), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset.
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);

    // Four patterns, all-zero responses: zero signature.
    resp.delete();
    for (int i = 0; i < 4; i++) resp.push_back('0);
    do_run(17'h1, 4, 17'h0, 0);
    do_run(17'h1, 4, 17'h5, 0);

    // Zero-length run skips RUN/FLUSH.
    do_run(17'h3, 0, 17'h0, 0);

`ifdef LBIST_CTRL_MISR_EN
    resp.delete();
    resp.push_back(17'h1); resp.push_back(17'h2);
    do_run(17'h9, 2, 17'h0, 0);
    do_run(17'h9, 2, 17'h1, 0);
`else
    resp.delete();
    resp.push_back(17'h1); resp.push_back(17'h2); resp.push_back(17'h4);
    do_run(17'h9, 3, 17'h7, 0);
    do_run(17'h9, 3, 17'h3, 0);
`endif

    // Random responses, matching and mismatching golden.
    resp.delete();
    for (int i = 0; i < 6; i++) resp.push_back(RESP_W'($urandom));
    do_run(17'h1ABCD, 6, calc_sig(6), 0);
    do_run(17'h00F0F, 6, calc_sig(6) ^ 17'h10000, 0);

    // Aborts: third RUN cycle, SEED, FLUSH, COMPARE.
    resp.delete();
    for (int i = 0; i < 8; i++) resp.push_back(RESP_W'($urandom));
    do_run(17'h12345, 8, 17'h0, 4);
    do_run(17'h00055, 5, 17'h0, 1);
    do_run(17'h00077, 3, calc_sig(3), 5);
    do_run(17'h00099, 3, calc_sig(3), 6);

    // Start with abort in IDLE: nothing happens.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; seed = 17'h5; num_patterns = 16'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("start_abort_busy2", 64'(busy), 64'd0);
    check("start_abort_seed", 64'(lfsr_seed), 64'(17'h00099));

    // Reset mid-run at pat_count=5.
    @(negedge clk);
    start = 1'b1; seed = 17'h42; num_patterns = 16'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrun_pat_count", 64'(pat_count), 64'd5);
    check("midrun_pat_valid", 64'(pat_valid), 64'd1);
    #2 reset = 1'b0;
    #1 check_reset_vals("midrun_rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after_rst_idle", 64'(busy), 64'd0);
    end
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
